// File: rtl/sim_entropy_source_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sim_entropy_source_pkg
// Purpose : Shared constants and types for the simulation-only fake entropy
//           source: LFSR width and tap mask, default seed, FSM encoding and
//           the single-step LFSR helper.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package sim_entropy_source_pkg;

   localparam int          LFSR_WIDTH   = 32;
   localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

   // Wide enough to count up to the largest legal word width (64).
   localparam int          CNT_WIDTH    = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VALID   = 2'd2
   } state_e;

   // Galois right-shift step: the bit shifted out of position 0 decides
   // whether the tap mask is folded back in.
   function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sim_entropy_source_lfsr32.sv
`default_nettype none
// ============================================================================
// Module  : sim_lfsr32
// Purpose : 32-bit Galois LFSR that advances one step per cycle when 'step'
//           is high and otherwise holds. Loads 'seed' on reset.
// Ports   : clk      in  clock
//           reset_n  in  asynchronous active-low reset
//           step     in  advance the LFSR this cycle
//           seed     in  value loaded on reset (must be nonzero)
//           state    out current LFSR contents
// Revision: 1.0  initial release
// ============================================================================
module sim_lfsr32
   import sim_entropy_source_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  step,
   input  logic [LFSR_WIDTH-1:0] seed,
   output logic [LFSR_WIDTH-1:0] state
);

   logic [LFSR_WIDTH-1:0] state_q;
   logic [LFSR_WIDTH-1:0] state_d;

   always_comb begin
      state_d = state_q;
      if (step) begin
         state_d = lfsr_next(state_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= seed;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/sim_entropy_source.sv
`default_nettype none
// ============================================================================
// Module  : sim_entropy_source
// Purpose : Simulation-only fake entropy source. A seeded LFSR bit stream is
//           collected into DATA_WIDTH-bit words and offered on a syn/ack
//           handshake. Provides no real entropy; never synthesise into a
//           product.
// Ports   : clk           in  clock
//           reset_n       in  asynchronous active-low reset
//           enable        in  run request; low aborts to IDLE
//           stuck_mode    in  force collected bits to 0
//           raw_entropy   out LFSR state while running, else 0
//           stats         out saturating count of acked words
//           enabled       out high while the FSM is not IDLE
//           entropy_syn   out word valid
//           entropy_data  out word (0 while syn is low)
//           entropy_ack   in  consumer accepts the word
// Revision: 1.0  initial release
// ============================================================================
module sim_entropy_source
   import sim_entropy_source_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] SEED       = DEFAULT_SEED
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  stuck_mode,
   output logic [31:0]           raw_entropy,
   output logic [31:0]           stats,
   output logic                  enabled,
   output logic                  entropy_syn,
   output logic [DATA_WIDTH-1:0] entropy_data,
   input  logic                  entropy_ack
);

   generate
      if ((DATA_WIDTH < 8) || (DATA_WIDTH > 64)) begin : g_bad_width
         $error("sim_entropy_source: DATA_WIDTH must be within 8..64");
      end
      if (SEED == 32'h0) begin : g_bad_seed
         $error("sim_entropy_source: SEED must be nonzero");
      end
   endgenerate

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
   logic [DATA_WIDTH-1:0] col_q,   col_d;
   logic [31:0]           stats_q, stats_d;

   logic [LFSR_WIDTH-1:0] lfsr_state;
   logic                  lfsr_step;
   logic                  new_bit;

   // The LFSR advances exactly once per collected bit; an abort edge
   // (enable low) collects nothing, so it does not step either.
   assign lfsr_step = (state_q == ST_COLLECT) && enable;
   assign new_bit   = stuck_mode ? 1'b0 : lfsr_state[0];

   sim_lfsr32 u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .step    (lfsr_step),
      .seed    (SEED),
      .state   (lfsr_state)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      stats_d = stats_q;

      if (!enable) begin
         // Abort: any pending word is dropped without being counted.
         state_d = ST_IDLE;
         cnt_d   = '0;
         col_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_COLLECT;
               cnt_d   = '0;
               col_d   = '0;
            end
            ST_COLLECT: begin
               col_d = {col_q[DATA_WIDTH-2:0], new_bit};
               cnt_d = cnt_q + CNT_WIDTH'(1);
               if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                  state_d = ST_VALID;
               end
            end
            ST_VALID: begin
               if (entropy_ack) begin
                  state_d = ST_COLLECT;
                  cnt_d   = '0;
                  col_d   = '0;
                  if (stats_q != 32'hFFFF_FFFF) begin
                     stats_d = stats_q + 32'd1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               col_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         col_q   <= '0;
         stats_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         stats_q <= stats_d;
      end
   end

   assign enabled      = (state_q != ST_IDLE);
   assign entropy_syn  = (state_q == ST_VALID);
   assign entropy_data = entropy_syn ? col_q : '0;
   assign raw_entropy  = enabled ? lfsr_state : 32'h0;
   assign stats        = stats_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_entropy_source.sv
`default_nettype none
// ============================================================================
// Module  : tb_sim_entropy_source
// Purpose : Self-checking bench for sim_entropy_source (widths 32, 8, 64)
//           against a bit-stream reference model of the LFSR.
// Revision: 1.0  initial release
// ============================================================================
module tb_sim_entropy_source;

   logic        clk;
   logic        reset_n;
   logic        enable, stuck, ack;
   logic        en_s, ack_s;

   logic [31:0] raw32, stats32;
   logic        enabled32, syn32;
   logic [31:0] data32;

   logic [31:0] raw8, stats8, raw64, stats64;
   logic        enabled8, syn8, enabled64, syn64;
   logic [7:0]  data8;
   logic [63:0] data64;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [31:0] m32;

   sim_entropy_source #(.DATA_WIDTH(32), .SEED(32'h1)) dut32 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .stuck_mode(stuck),
      .raw_entropy(raw32), .stats(stats32), .enabled(enabled32),
      .entropy_syn(syn32), .entropy_data(data32), .entropy_ack(ack));

   sim_entropy_source #(.DATA_WIDTH(8), .SEED(32'h1)) dut8 (
      .clk(clk), .reset_n(reset_n), .enable(en_s), .stuck_mode(1'b0),
      .raw_entropy(raw8), .stats(stats8), .enabled(enabled8),
      .entropy_syn(syn8), .entropy_data(data8), .entropy_ack(ack_s));

   sim_entropy_source #(.DATA_WIDTH(64), .SEED(32'h1)) dut64 (
      .clk(clk), .reset_n(reset_n), .enable(en_s), .stuck_mode(1'b0),
      .raw_entropy(raw64), .stats(stats64), .enabled(enabled64),
      .entropy_syn(syn64), .entropy_data(data64), .entropy_ack(ack_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: produce 'width' output bits of the Galois LFSR, first bit in
   // the word MSB; bits from index stuck_from onward read as 0 but still
   // consume an LFSR step.
   task automatic model_word(inout logic [31:0] lfsr, input int width,
                             input int stuck_from, output logic [63:0] word);
      word = 64'h0;
      for (int i = 0; i < width; i++) begin
         word = {word[62:0], (i < stuck_from) ? lfsr[0] : 1'b0};
         lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
      end
   endtask

   // Ticks until syn32 is high (bounded); returns the number of ticks taken.
   task automatic wait_syn(output int n);
      n = 0;
      while (!syn32 && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      logic [63:0] w;
      logic [31:0] held_raw;
      int          n, d, j;
      int          l8, l64;
      logic [63:0] d8, d64;
      logic [31:0] tmp;

      reset_n = 1'b0; enable = 1'b0; stuck = 1'b0; ack = 1'b0;
      en_s = 1'b0; ack_s = 1'b0;
      m32 = 32'h1;

      // ---------------- reset state ----------------
      repeat (3) tick();
      check("rst_syn",     syn32,     0);
      check("rst_data",    data32,    0);
      check("rst_stats",   stats32,   0);
      check("rst_enabled", enabled32, 0);
      check("rst_raw",     raw32,     0);
      check("rst_syn64",   syn64,     0);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_raw", raw32, 0);
         check("idle_syn", syn32, 0);
      end
      check("idle_enabled", enabled32, 0);
      check("idle_stats",   stats32,   0);

      // ---------------- first word ----------------
      enable = 1'b1; ack = 1'b1;
      tick();
      check("enabled_rise", enabled32, 1);
      check("raw_running",  raw32, 32'h1);
      wait_syn(n);
      check("first_latency", n + 1, 33);
      model_word(m32, 32, 32, w);
      check("first_word", data32, w);
      tmp = data32;
      check("first_nibble", tmp[31:28], 4'hD);
      tick();
      check("first_stats", stats32, 1);
      check("first_syn_drop", syn32, 0);

      // ---------------- throughput, ack tied high ----------------
      for (int k = 2; k <= 10; k++) begin
         wait_syn(n);
         check("tp_period", n + 1, 33);
         model_word(m32, 32, 32, w);
         check("tp_word", data32, w);
         tick();
      end
      check("tp_stats", stats32, 10);

      // ---------------- backpressure and abort ----------------
      ack = 1'b0;
      wait_syn(n);
      check("bp_latency", n, 32);
      model_word(m32, 32, 32, w);
      check("bp_word", data32, w);
      held_raw = raw32;
      repeat (50) tick();
      check("bp_data_stable", data32, w);
      check("bp_lfsr_frozen", raw32, held_raw);
      check("bp_syn_held",    syn32, 1);
      enable = 1'b0; ack = 1'b1;
      tick();
      check("abort_syn",     syn32,     0);
      check("abort_enabled", enabled32, 0);
      check("abort_data",    data32,    0);
      check("abort_raw",     raw32,     0);
      check("abort_stats",   stats32,   10);
      repeat ($urandom_range(1, 8)) tick();
      enable = 1'b1;
      wait_syn(n);
      check("reen_latency", n, 33);
      model_word(m32, 32, 32, w);
      check("reen_word", data32, w);
      tick();
      check("reen_stats", stats32, 11);

      // ---------------- randomized ack delays ----------------
      ack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_syn(n);
         check("rd_latency", n, 32);
         model_word(m32, 32, 32, w);
         check("rd_word", data32, w);
         d = $urandom_range(0, 6);
         repeat (d) tick();
         check("rd_hold_data", data32, w);
         check("rd_hold_syn",  syn32, 1);
         ack = 1'b1;
         tick();
         check("rd_syn_drop", syn32, 0);
         ack = 1'b0;
      end
      check("rd_stats", stats32, 15);

      // ---------------- stuck mode ----------------
      stuck = 1'b1;
      wait_syn(n);
      check("stuck_latency", n, 32);
      model_word(m32, 32, 0, w);
      check("stuck_word", data32, 0);
      stuck = 1'b0; ack = 1'b1;
      tick();
      ack = 1'b0;
      wait_syn(n);
      check("unstuck_latency", n, 32);
      model_word(m32, 32, 32, w);
      check("unstuck_word", data32, w);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      j = $urandom_range(1, 31);
      repeat (j) tick();
      stuck = 1'b1;
      wait_syn(n);
      check("pstuck_latency", n, 32 - j);
      model_word(m32, 32, j, w);
      check("pstuck_word", data32, w);
      stuck = 1'b0; ack = 1'b1;
      tick();
      ack = 1'b0;
      check("stuck_stats", stats32, 18);

      // ---------------- stats saturation ----------------
      force dut32.stats_q = 32'hFFFF_FFFE;
      tick();
      release dut32.stats_q;
      check("sat_preload", stats32, 32'hFFFF_FFFE);
      wait_syn(n);
      check("sat_latency1", n, 31);
      model_word(m32, 32, 32, w);
      check("sat_word1", data32, w);
      ack = 1'b1;
      tick();
      check("sat_stats1", stats32, 32'hFFFF_FFFF);
      wait_syn(n);
      check("sat_latency2", n, 32);
      model_word(m32, 32, 32, w);
      check("sat_word2", data32, w);
      tick();
      check("sat_stats2", stats32, 32'hFFFF_FFFF);
      ack = 1'b0;

      // ---------------- asynchronous reset mid-word ----------------
      repeat (5) tick();
      #3 reset_n = 1'b0;
      #1;
      check("arst_syn",     syn32,     0);
      check("arst_enabled", enabled32, 0);
      check("arst_data",    data32,    0);
      check("arst_raw",     raw32,     0);
      check("arst_stats",   stats32,   0);
      #1 reset_n = 1'b1;
      m32 = 32'h1;
      wait_syn(n);
      check("arst_latency", n, 33);
      model_word(m32, 32, 32, w);
      check("arst_word", data32, w);
      enable = 1'b0;
      tick();

      // ---------------- width sweep: 8 and 64 ----------------
      en_s = 1'b1; ack_s = 1'b1;
      l8 = 0; l64 = 0; d8 = '0; d64 = '0;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (syn8 && l8 == 0) begin
            l8 = c;
            d8 = {56'h0, data8};
         end
         if (syn64 && l64 == 0) begin
            l64 = c;
            d64 = data64;
         end
         if (l8 != 0 && l64 != 0) break;
      end
      check("w8_latency",  l8,  9);
      check("w64_latency", l64, 65);
      tmp = 32'h1;
      model_word(tmp, 8, 8, w);
      check("w8_word", d8, w);
      tmp = 32'h1;
      model_word(tmp, 64, 64, w);
      check("w64_word", d64, w);
      tick();
      check("w64_stats", stats64, 1);
      check("w8_stats",  stats8,  7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sim_entropy_source.md
# sim_entropy_source

Simulation-only, parametrised fake entropy source for the trng testbenches. It replaces a physical noise source: a seeded Galois LFSR produces a deterministic, reproducible bit stream, collects it into words and delivers them over the standard syn/ack entropy handshake. It also keeps a delivered-word counter and has a stuck-output mode, so that the mixer and the health tests can be exercised. It provides NO real entropy and must never be synthesised into a product.

## Interface
Parameters:
- DATA_WIDTH, default 32: entropy word width, legal range 8..64.
- SEED, default 32'h00000001: initial LFSR state on reset; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- stuck_mode  in  1  force every collected bit to 0 (health-test stimulus).
- raw_entropy  out  32  current LFSR state when enabled, else 0.
- stats  out  32  count of acked words, saturating.
- enabled  out  1  registered; high while the FSM is not IDLE.
- entropy_syn  out  1  word valid.
- entropy_data  out  DATA_WIDTH  word; 0 when syn is low.
- entropy_ack  in  1  consumer accepts the word.

## Operation
- LFSR, 32-bit Galois, right shift:
  - next = (lfsr >> 1) ^ (lfsr[0] ? 32'h80200003 : 0).
  - Output bit = lfsr[0] before the step.
- Collected bit = stuck_mode ? 0 : lfsr[0].
- LFSR steps only in COLLECT, whether or not stuck_mode is set. It holds its value in IDLE and VALID.
- FSM states are IDLE, COLLECT and VALID.
  - IDLE: bit counter 0, collect register 0. Leaves for COLLECT when enable is sampled high.
  - COLLECT: each cycle, collect register = {reg[DATA_WIDTH-2:0], bit} and the counter increments. After the DATA_WIDTH-th shift, go to VALID.
  - VALID: entropy_syn = 1 and entropy_data = collect register, held stable. When entropy_ack is sampled high: stats increments, then go to COLLECT with the counter and collect register cleared.
- In any state, enable sampled low → IDLE on the next edge. Any pending word is discarded and not counted. The LFSR is not reseeded.
- An ack while syn is low is ignored.
- stats saturates at 32'hFFFFFFFF. Only reset clears it.
- stuck_mode may change at any time. It affects only bits shifted after the edge on which it is sampled.

## Timing
- Reset values:
  - state IDLE, lfsr = SEED.
  - counter 0, collect register 0.
  - stats 0, enabled 0, entropy_syn 0, entropy_data 0, raw_entropy 0.
- enable sampled high at edge E:
  - enabled goes high after E.
  - Shifts happen at edges E+1 .. E+DATA_WIDTH.
  - entropy_syn goes high after edge E+DATA_WIDTH, i.e. DATA_WIDTH+1 cycles of latency.
- entropy_ack sampled at edge A while syn is high:
  - syn is low after A.
  - The next word's shifts happen at edges A+1 .. A+DATA_WIDTH.
  - Steady-state throughput is one word per DATA_WIDTH+1 cycles, given an immediate ack.
- entropy_ack may be held high continuously. Each word is accepted at its first VALID cycle.
- enable low at edge D: syn, enabled and data are 0 after D.
- Simultaneous enable-low and ack at the same edge: enable wins. The word is dropped and stats is unchanged.
- Asynchronous reset mid-word: every output returns to its reset value immediately. Collection restarts from SEED.

## Structure
- A shared sim package holds:
  - LFSR width (32) and tap mask 32'h80200003;
  - the default seed;
  - the FSM state encoding.
- Sub-module sim_lfsr32: ports clk, reset_n, step, seed, state. Step logic only. The FSM, counter, collect register and statistics stay in the top.
- The file lives with the other fake modules under the testbench tree. It is excluded from all synthesis file lists.

## Test plan
- Reset check: while reset_n is low, all outputs read 0. After release with enable=0 for 10 cycles, outputs stay 0 and raw_entropy stays 0.
- First word: SEED=1, DATA_WIDTH=32, enable high at edge 0, ack held high.
  - syn rises after edge 32.
  - entropy_data[31:28] = 4'b1101.
  - The full word matches a bit-exact LFSR reference model.
  - stats = 1 after the ack edge.
- Throughput: ack tied high for 10 words. syn pulses exactly every 33 cycles, each word matches the model, and stats = 10.
- Backpressure and abort:
  - Hold ack low for 50 cycles: data is stable and the LFSR is frozen.
  - Drop enable together with ack: stats is unchanged.
  - Re-enable: the next word continues the LFSR sequence, with no reseed.
- Stuck mode: stuck_mode=1 for a whole word gives entropy_data = 0x00000000. Clearing it resumes model-matching words, offset by the LFSR steps consumed.
- Parameter sweep and saturation:
  - DATA_WIDTH=8 and 64 give latencies of 9 and 65 cycles.
  - Forcing stats to 32'hFFFFFFFE, then two acks, leaves it at 32'hFFFFFFFF.
